// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch bookkeeping queue.
package branch_resolver_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int BRANCH_QUEUE_SIZE = 8;
  localparam int DEPTH = BRANCH_QUEUE_SIZE;
  localparam int TAG_W = $clog2(DEPTH);

  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [TAG_W:0]        cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam tag_t BRANCH_TAG_ZERO = '0;

  typedef struct packed {
    logic  valid;
    logic  resolved;
    logic  pred_taken;
    logic  taken;
    data_t pc;
    data_t pred_pc;
    data_t act_pc;
  } br_entry_t;

  function automatic data_t next_pc(
    input logic  taken,
    input data_t target,
    input data_t pc
  );
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Issue / resolve / retire bundle between decode, branch ALU and PC unit.
interface branch_resolver_if;
  import branch_resolver_pkg::*;

  logic  in_issue_valid;
  data_t in_issue_pc;
  logic  in_issue_pred_taken;
  data_t in_issue_pred_pc;
  tag_t  out_issue_tag;
  logic  out_full;

  logic  in_resolve_valid;
  tag_t  in_resolve_tag;
  logic  in_resolve_taken;
  data_t in_resolve_target;

  logic  out_branch_valid;
  logic  out_misbranch;
  logic  out_branch_taken;
  data_t out_branch_pc;
  data_t out_correct_address;

  modport master (
    output in_issue_valid, in_issue_pc,
    output in_issue_pred_taken, in_issue_pred_pc,
    input  out_issue_tag, out_full,
    output in_resolve_valid, in_resolve_tag,
    output in_resolve_taken, in_resolve_target,
    input  out_branch_valid, out_misbranch,
    input  out_branch_taken, out_branch_pc,
    input  out_correct_address
  );

  modport slave (
    input  in_issue_valid, in_issue_pc,
    input  in_issue_pred_taken, in_issue_pred_pc,
    output out_issue_tag, out_full,
    input  in_resolve_valid, in_resolve_tag,
    input  in_resolve_taken, in_resolve_target,
    output out_branch_valid, out_misbranch,
    output out_branch_taken, out_branch_pc,
    output out_correct_address
  );

endinterface

// File: rtl/branch_resolver.sv
// In-order branch queue: out-of-order resolve, in-order retire, flush.
// Optional retire/mispredict counters with `define BRANCH_STAT_EN.
module branch_resolver
  import branch_resolver_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ena,
`ifdef BRANCH_STAT_EN
  output logic [31:0] out_stat_retired,
  output logic [31:0] out_stat_mispredict,
`endif
  branch_resolver_if.slave bus
);

  br_entry_t ent_q [DEPTH];
  br_entry_t ent_d [DEPTH];
  tag_t  head_q, head_d;
  tag_t  tail_q, tail_d;
  cnt_t  cnt_q, cnt_d;
  logic  valid_q, valid_d;
  logic  mis_q, mis_d;
  logic  taken_q, taken_d;
  data_t pc_q, pc_d;
  data_t addr_q, addr_d;

  logic full;
  logic issue_ok;
  logic resolve_ok;
  logic retire_ok;
  logic retire_mis;
  br_entry_t hd;

  assign full = (cnt_q == cnt_t'(DEPTH));
  assign hd   = ent_q[head_q];

  assign issue_ok   = ena && bus.in_issue_valid && !full && !mis_q;
  assign resolve_ok = ena && bus.in_resolve_valid && !mis_q
                      && ent_q[bus.in_resolve_tag].valid;
  assign retire_ok  = ena && hd.valid && hd.resolved && !mis_q;
  assign retire_mis = retire_ok && (hd.act_pc != hd.pred_pc);

  // pred_taken is kept for predictor bookkeeping but never feeds logic
  logic unused_pred;
  always_comb begin
    unused_pred = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      unused_pred = unused_pred ^ ent_q[i].pred_taken;
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    valid_d = FALSE;
    mis_d   = FALSE;
    taken_d = taken_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (issue_ok) begin
      ent_d[tail_q].valid      = TRUE;
      ent_d[tail_q].resolved   = FALSE;
      ent_d[tail_q].pred_taken = bus.in_issue_pred_taken;
      ent_d[tail_q].taken      = FALSE;
      ent_d[tail_q].pc         = bus.in_issue_pc;
      ent_d[tail_q].pred_pc    = bus.in_issue_pred_pc;
      ent_d[tail_q].act_pc     = ZERO_DATA;
      tail_d = tail_q + 1'b1;
    end
    if (resolve_ok) begin
      ent_d[bus.in_resolve_tag].resolved = TRUE;
      ent_d[bus.in_resolve_tag].taken    = bus.in_resolve_taken;
      ent_d[bus.in_resolve_tag].act_pc   = next_pc(
        bus.in_resolve_taken, bus.in_resolve_target,
        ent_q[bus.in_resolve_tag].pc);
    end
    if (retire_ok) begin
      valid_d = TRUE;
      mis_d   = retire_mis;
      taken_d = hd.taken;
      pc_d    = hd.pc;
      addr_d  = hd.act_pc;
      ent_d[head_q].valid    = FALSE;
      ent_d[head_q].resolved = FALSE;
      head_d = head_q + 1'b1;
    end
    cnt_d = cnt_q + cnt_t'(issue_ok) - cnt_t'(retire_ok);
    // a mispredict wipes everything younger, including this edge's inputs
    if (retire_mis) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid    = FALSE;
        ent_d[i].resolved = FALSE;
      end
      head_d = BRANCH_TAG_ZERO;
      tail_d = BRANCH_TAG_ZERO;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= BRANCH_TAG_ZERO;
      tail_q  <= BRANCH_TAG_ZERO;
      cnt_q   <= '0;
      valid_q <= FALSE;
      mis_q   <= FALSE;
      taken_q <= FALSE;
      pc_q    <= ZERO_DATA;
      addr_q  <= ZERO_DATA;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      taken_q <= taken_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_ret_q, stat_mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ret_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (retire_ok)  stat_ret_q <= stat_ret_q + 32'd1;
      if (retire_mis) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign out_stat_retired    = stat_ret_q;
  assign out_stat_mispredict = stat_mis_q;
`endif

  assign bus.out_issue_tag       = tail_q;
  assign bus.out_full            = full;
  assign bus.out_branch_valid    = valid_q;
  assign bus.out_misbranch       = mis_q;
  assign bus.out_branch_taken    = taken_q;
  assign bus.out_branch_pc       = pc_q;
  assign bus.out_correct_address = addr_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed-vector bench for branch_resolver.
module tb_branch_resolver;

  logic clk;
  logic rst;
  logic ena;
  int   n_cmp;
  int   n_err;

  branch_resolver_if bus ();

  branch_resolver dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.in_issue_valid      = 1'b0;
    bus.in_issue_pc         = '0;
    bus.in_issue_pred_taken = 1'b0;
    bus.in_issue_pred_pc    = '0;
    bus.in_resolve_valid    = 1'b0;
    bus.in_resolve_tag      = '0;
    bus.in_resolve_taken    = 1'b0;
    bus.in_resolve_target   = '0;
  endtask

  task automatic set_iss(input logic [31:0] pc, input logic [31:0] pp);
    bus.in_issue_valid      = 1'b1;
    bus.in_issue_pc         = pc;
    bus.in_issue_pred_taken = (pp != pc + 32'd4);
    bus.in_issue_pred_pc    = pp;
  endtask

  task automatic set_res(input logic [2:0] t, input logic tk,
                         input logic [31:0] tgt);
    bus.in_resolve_valid  = 1'b1;
    bus.in_resolve_tag    = t;
    bus.in_resolve_taken  = tk;
    bus.in_resolve_target = tgt;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] pp);
    set_iss(pc, pp);
    step();
    clr();
  endtask

  task automatic resolve(input logic [2:0] t, input logic tk,
                         input logic [31:0] tgt);
    set_res(t, tk, tgt);
    step();
    clr();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ena = 1'b1;
    rst = 1'b1;
    clr();
    #12;
    chk("rst_valid", 32'(bus.out_branch_valid), 32'd0);
    chk("rst_mis",   32'(bus.out_misbranch), 32'd0);
    chk("rst_full",  32'(bus.out_full), 32'd0);
    chk("rst_tag",   32'(bus.out_issue_tag), 32'd0);
    chk("rst_pc",    bus.out_branch_pc, 32'd0);
    step();
    rst = 1'b0;

    // correct not-taken
    issue(32'h100, 32'h104);
    chk("t1_tag", 32'(bus.out_issue_tag), 32'd1);
    resolve(3'd0, 1'b0, 32'h0);
    chk("t1_nort", 32'(bus.out_branch_valid), 32'd0);
    step();
    chk("t1_valid", 32'(bus.out_branch_valid), 32'd1);
    chk("t1_mis",   32'(bus.out_misbranch), 32'd0);
    chk("t1_addr",  bus.out_correct_address, 32'h104);
    chk("t1_pc",    bus.out_branch_pc, 32'h100);
    chk("t1_taken", 32'(bus.out_branch_taken), 32'd0);
    step();
    chk("t1_fall",  32'(bus.out_branch_valid), 32'd0);
    chk("t1_hold",  bus.out_branch_pc, 32'h100);

    // mispredict with flush
    issue(32'h200, 32'h204);
    resolve(3'd1, 1'b1, 32'h180);
    step();
    chk("t2_valid", 32'(bus.out_branch_valid), 32'd1);
    chk("t2_mis",   32'(bus.out_misbranch), 32'd1);
    chk("t2_taken", 32'(bus.out_branch_taken), 32'd1);
    chk("t2_addr",  bus.out_correct_address, 32'h180);
    chk("t2_pc",    bus.out_branch_pc, 32'h200);
    chk("t2_full",  32'(bus.out_full), 32'd0);
    chk("t2_tag",   32'(bus.out_issue_tag), 32'd0);
    set_iss(32'h222, 32'h226);
    set_res(3'd0, 1'b0, 32'h0);
    step();
    clr();
    chk("t2_ign_tag", 32'(bus.out_issue_tag), 32'd0);
    chk("t2_fallm",   32'(bus.out_misbranch), 32'd0);
    resolve(3'd1, 1'b0, 32'h0);
    step();
    chk("t2_stale", 32'(bus.out_branch_valid), 32'd0);

    // out-of-order resolve, in-order retire
    issue(32'h300, 32'h304);
    issue(32'h310, 32'h314);
    issue(32'h320, 32'h324);
    resolve(3'd2, 1'b0, 32'h0);
    resolve(3'd0, 1'b0, 32'h0);
    chk("t3_wait", 32'(bus.out_branch_valid), 32'd0);
    resolve(3'd1, 1'b0, 32'h0);
    chk("t3_r0v", 32'(bus.out_branch_valid), 32'd1);
    chk("t3_r0",  bus.out_branch_pc, 32'h300);
    step();
    chk("t3_r1v", 32'(bus.out_branch_valid), 32'd1);
    chk("t3_r1",  bus.out_branch_pc, 32'h310);
    step();
    chk("t3_r2",  bus.out_branch_pc, 32'h320);
    chk("t3_r2a", bus.out_correct_address, 32'h324);
    step();
    chk("t3_end", 32'(bus.out_branch_valid), 32'd0);

    // full and wrap
    do_reset();
    for (int i = 0; i < 8; i++)
      issue(32'h400 + 32'(i * 16), 32'h404 + 32'(i * 16));
    chk("t4_full", 32'(bus.out_full), 32'd1);
    chk("t4_ftag", 32'(bus.out_issue_tag), 32'd0);
    issue(32'h999, 32'h99d);
    chk("t4_ref",  32'(bus.out_full), 32'd1);
    chk("t4_rtag", 32'(bus.out_issue_tag), 32'd0);
    set_iss(32'h999, 32'h99d);
    set_res(3'd0, 1'b0, 32'h0);
    step();
    clr();
    chk("t4_still", 32'(bus.out_full), 32'd1);
    step();
    chk("t4_ret0",  bus.out_branch_pc, 32'h400);
    chk("t4_nfull", 32'(bus.out_full), 32'd0);
    chk("t4_ntag",  32'(bus.out_issue_tag), 32'd0);
    issue(32'h1000, 32'h1004);
    chk("t4_refull", 32'(bus.out_full), 32'd1);
    for (int k = 0; k < 8; k++) begin
      set_res(3'((k + 1) % 8), 1'b0, 32'h0);
      step();
      if (k > 0)
        chk("t4_drain", bus.out_branch_pc, 32'h400 + 32'(k * 16));
    end
    clr();
    step();
    chk("t4_ninth", bus.out_branch_pc, 32'h1000);
    chk("t4_nv",    32'(bus.out_branch_valid), 32'd1);
    step();
    chk("t4_empty", 32'(bus.out_branch_valid), 32'd0);

    // flush mid-queue
    do_reset();
    for (int i = 0; i < 4; i++)
      issue(32'h500 + 32'(i * 16), 32'h504 + 32'(i * 16));
    resolve(3'd2, 1'b0, 32'h0);
    resolve(3'd3, 1'b0, 32'h0);
    resolve(3'd1, 1'b1, 32'h800);
    resolve(3'd0, 1'b0, 32'h0);
    chk("t5_none", 32'(bus.out_branch_valid), 32'd0);
    step();
    chk("t5_r0",  bus.out_branch_pc, 32'h500);
    chk("t5_r0m", 32'(bus.out_misbranch), 32'd0);
    step();
    chk("t5_r1",  bus.out_branch_pc, 32'h510);
    chk("t5_r1m", 32'(bus.out_misbranch), 32'd1);
    chk("t5_r1a", bus.out_correct_address, 32'h800);
    step();
    chk("t5_gone", 32'(bus.out_branch_valid), 32'd0);
    chk("t5_tag",  32'(bus.out_issue_tag), 32'd0);
    step();
    chk("t5_gone2", 32'(bus.out_branch_valid), 32'd0);
    chk("t5_full",  32'(bus.out_full), 32'd0);

    // asynchronous reset mid-stream
    issue(32'h600, 32'h604);
    resolve(3'd0, 1'b0, 32'h0);
    step();
    chk("t6_pre", 32'(bus.out_branch_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rv",  32'(bus.out_branch_valid), 32'd0);
    chk("t6_rpc", bus.out_branch_pc, 32'd0);
    chk("t6_ra",  bus.out_correct_address, 32'd0);
    chk("t6_rt",  32'(bus.out_issue_tag), 32'd0);
    rst = 1'b0;

    // enable gating
    issue(32'h700, 32'h704);
    resolve(3'd0, 1'b0, 32'h0);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t7_frozen", 32'(bus.out_branch_valid), 32'd0);
    end
    chk("t7_pc0", bus.out_branch_pc, 32'd0);
    ena = 1'b1;
    step();
    chk("t7_go",  32'(bus.out_branch_valid), 32'd1);
    chk("t7_pc",  bus.out_branch_pc, 32'h700);
    step();
    chk("t7_end", 32'(bus.out_branch_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- In-order branch bookkeeping queue between decode/issue, the branch ALU and the PC/predictor.
- Records each issued conditional branch with its predicted next PC and accepts out-of-order resolutions from the branch ALU.
- Retires branches in program order, producing the branch forwarding / misbranch stream the PC unit consumes: predictor update, rollback and correct address.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- TAG_W, 3, tag width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  global enable; low freezes all state.
- in_issue_valid  in  1  a branch is issued this cycle.
- in_issue_pc  in  32  PC of the issued branch.
- in_issue_pred_taken  in  1  taken prediction used by fetch.
- in_issue_pred_pc  in  32  next PC fetch actually followed.
- out_issue_tag  out  TAG_W  tag assigned to the current issue; equals the tail pointer.
- out_full  out  1  queue full; issue not accepted.
- in_resolve_valid  in  1  branch ALU result valid.
- in_resolve_tag  in  TAG_W  tag of the resolved branch.
- in_resolve_taken  in  1  actual direction.
- in_resolve_target  in  32  taken target address.
- out_branch_valid  out  1  one-cycle pulse: a branch retired.
- out_misbranch  out  1  one-cycle pulse: retired branch was mispredicted.
- out_branch_taken  out  1  actual direction of the retired branch.
- out_branch_pc  out  32  PC of the retired branch.
- out_correct_address  out  32  actual next PC: target if taken, else pc+4.

Behaviour:
- Reset (asynchronous, immediate): head=tail=0; count=0; all entry valid/resolved bits cleared; all outputs 0.
- Storage: circular queue. head/tail are TAG_W bits and wrap modulo DEPTH. count is TAG_W+1 bits.
  - out_full = (count==DEPTH), derived combinationally from registered count.
  - out_issue_tag = tail, combinational.
- Issue: accepted at the edge when ena && in_issue_valid && !out_full && !out_misbranch.
  - Writes pc, pred_pc, pred_taken into entry[tail]; sets valid, clears resolved; tail+1.
  - When full, issue is refused even if a retire occurs in the same cycle. No bypass.
- Resolve: accepted when ena && in_resolve_valid && !out_misbranch && entry[tag].valid.
  - Stores the actual next PC: in_resolve_taken ? in_resolve_target : pc+4, 32-bit wrap.
  - Stores the taken bit; sets resolved.
  - Resolve to an invalid tag is silently ignored.
  - Re-resolve of an already resolved entry overwrites it.
- Retire: at an edge where ena && entry[head].valid && entry[head].resolved && !out_misbranch.
  - Outputs are registered: out_branch_valid=1, plus taken, pc and correct_address from the entry.
  - out_misbranch = (actual next PC != pred_pc).
  - Entry cleared; head+1.
  - At most one retire per cycle.
- Latency: resolve at edge N -> earliest retire decision at edge N+1 -> outputs visible in the cycle after N+1. Retire throughput is 1 per cycle.
- Misbranch flush: at the edge that retires a mispredicted branch, all entries are invalidated, head=tail=0 and count=0.
  - Any issue or resolve presented at that edge is discarded.
  - During the cycle out_misbranch is high, issue and resolve inputs are ignored, because upstream is flushing.
- Simultaneous issue and retire (not full): count unchanged, both pointers advance.
- Simultaneous resolve and retire on the head tag: the resolve is written; retire of that entry happens next cycle.
- Empty queue: no retire; out_branch_valid=0.
- Pulse outputs: out_branch_valid and out_misbranch fall to 0 the cycle after the pulse unless another retire occurs. They are forced to 0 at any edge where ena=0.
- Data outputs (taken, pc, correct_address) hold their last value when no retire occurs.
- ena=0: no pointer, entry or count changes.
- Reset asserted mid-operation clears everything asynchronously, with no partial retire.

Optional Feature:
- BRANCH_STAT_EN defined:
  - Adds outputs out_stat_retired[31:0] and out_stat_mispredict[31:0].
  - Counts retires and mispredicted retires; both wrap at 2^32 and reset to 0.
- BRANCH_STAT_EN undefined: these ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- constant.v: reuse DATA_WIDTH, ZERO_DATA, TRUE, FALSE.
- Add BRANCH_QUEUE_SIZE (8), BRANCH_TAG_WIDTH range macro, and BRANCH_TAG_ZERO.
- Single module; the entry array and pointers stay inline. No sub-module needed.

Test Plan:
- Correct not-taken: issue pc=0x100, pred_taken=0, pred_pc=0x104, tag 0; resolve tag 0 taken=0 -> pulse branch_valid=1, misbranch=0, correct_address=0x104, pc=0x100.
- Mispredict: issue pc=0x200, pred_pc=0x204; resolve taken=1, target=0x180 -> misbranch=1, branch_taken=1, correct_address=0x180; next cycle out_full=0, out_issue_tag=0, and a resolve with a stale tag is ignored.
- Out-of-order resolve: issue tags 0,1,2; resolve 2, then 0, then 1 -> retires in order 0,1,2 on consecutive cycles starting after tag 0 resolves.
- Full/wrap: issue 8 branches -> out_full=1 and a 9th issue is refused. Retire 1 and issue 1 -> the new tag is 0 and is the 9th branch.
- Flush mid-queue: tags 0..3 issued; tag 1 mispredicts with 2 and 3 already resolved -> 2 and 3 are never retired; count=0.
- Reset/enable: assert rst mid-stream -> outputs go to 0 immediately. With ena=0 and a resolved head, nothing retires until ena=1.
